// File: rtl/out_buf_writer_pkg.sv
// Shared constants and state encoding for the output sample buffer writer.
package out_buf_writer_pkg;

  localparam int OUTBUF_DEPTH = 768;
  localparam int OUTBUF_AW    = 10;
  localparam int SAMPLE_W     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } outbuf_state_t;

endpackage : out_buf_writer_pkg

// File: rtl/out_buf_writer_sat_gain.sv
// sat_gain: signed sample times unsigned Q0.8 gain, arithmetic shift by 8,
// clamped to the signed 16-bit range. Purely combinational.
module sat_gain
  import out_buf_writer_pkg::*;
(
  input  logic [SAMPLE_W-1:0] din,
  input  logic [7:0]          gain,
  output logic [SAMPLE_W-1:0] dout
);

  logic signed [24:0] prod_s;
  logic signed [24:0] shifted_s;

  // Gain is zero-extended so it multiplies as a non-negative value.
  assign prod_s    = $signed(din) * $signed({1'b0, gain});
  assign shifted_s = prod_s >>> 8;

  // Clamp the scaled product into the 16-bit two's complement range.
  always_comb begin
    dout = shifted_s[SAMPLE_W-1:0];
    if (shifted_s > 25'sd32767) begin
      dout = 16'h7FFF;
    end else if (shifted_s < -25'sd32768) begin
      dout = 16'h8000;
    end else begin
      dout = shifted_s[SAMPLE_W-1:0];
    end
  end

endmodule : sat_gain

// File: rtl/out_buf_writer.sv
// out_buf_writer: write-side front end of the output sample buffer.
// Takes samples on a valid/ready handshake, writes them at a wrapping address
// one cycle later, and tracks occupancy against the read-side consume strobe.
// Optional feature macro: OUTBUF_GAIN_EN (applies saturating Q0.8 gain).
module out_buf_writer
  import out_buf_writer_pkg::*;
#(
  parameter int DEPTH     = OUTBUF_DEPTH,
  parameter int ADDR_BITS = OUTBUF_AW,
  parameter int DATA_BITS = SAMPLE_W
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  input  logic [7:0]           gain,
  input  logic                 ready,
  output logic [ADDR_BITS-1:0] Outa,
  output logic [DATA_BITS-1:0] Outd,
  output logic                 OutBufWea,
  output logic                 primed,
  output logic [ADDR_BITS-1:0] level,
  output logic                 frame_done,
  output logic                 underrun,
  output logic                 overrun
);

  localparam logic [ADDR_BITS-1:0] FULL_LVL  = ADDR_BITS'(DEPTH);
  localparam logic [ADDR_BITS-1:0] HALF_LVL  = ADDR_BITS'(DEPTH / 2);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] ONE       = ADDR_BITS'(1);

  outbuf_state_t        state_r, state_n;
  logic [ADDR_BITS-1:0] wptr_r, wptr_n;
  logic [ADDR_BITS-1:0] level_r, level_n;
  logic                 primed_r, primed_n;
  logic                 underrun_r, underrun_n;
  logic                 overrun_r, overrun_n;
  logic                 wea_r, wea_n;
  logic [ADDR_BITS-1:0] outa_r, outa_n;
  logic [DATA_BITS-1:0] outd_r, outd_n;
  logic                 fd_r, fd_n;

  logic                 in_ready_s;
  logic                 accept_s;
  logic                 consume_s;
  logic [DATA_BITS-1:0] proc_s;

`ifdef OUTBUF_GAIN_EN
  sat_gain u_sat_gain (
    .din  (in_data),
    .gain (gain),
    .dout (proc_s)
  );
`else
  logic unused_gain_s;
  assign unused_gain_s = ^gain;
  assign proc_s        = in_data;
`endif

  assign in_ready_s = (state_r != IDLE) && (level_r != FULL_LVL);
  assign accept_s   = in_valid && in_ready_s;
  // Reads only drain occupancy while streaming and something is buffered.
  assign consume_s  = ready && (state_r == STREAM) && (level_r != {ADDR_BITS{1'b0}});

  // Next-state, occupancy, flags and write-port values; flush overrides all.
  always_comb begin
    state_n    = state_r;
    wptr_n     = wptr_r;
    level_n    = level_r;
    primed_n   = primed_r;
    underrun_n = underrun_r;
    overrun_n  = overrun_r;
    wea_n      = 1'b0;
    outa_n     = outa_r;
    outd_n     = outd_r;
    fd_n       = 1'b0;

    if (flush) begin
      state_n    = IDLE;
      wptr_n     = {ADDR_BITS{1'b0}};
      level_n    = {ADDR_BITS{1'b0}};
      primed_n   = 1'b0;
      underrun_n = 1'b0;
      overrun_n  = 1'b0;
    end else begin
      if (accept_s) begin
        wea_n  = 1'b1;
        outa_n = wptr_r;
        outd_n = proc_s;
        fd_n   = (wptr_r == LAST_ADDR);
        wptr_n = (wptr_r == LAST_ADDR) ? {ADDR_BITS{1'b0}} : (wptr_r + ONE);
      end else begin
        wea_n = 1'b0;
      end

      case ({accept_s, consume_s})
        2'b10:   level_n = level_r + ONE;
        2'b01:   level_n = level_r - ONE;
        default: level_n = level_r;
      endcase

      case (state_r)
        IDLE: begin
          if (start) begin
            state_n = PRIME;
          end else begin
            state_n = IDLE;
          end
        end
        PRIME: begin
          if (ready) begin
            overrun_n = 1'b1;
          end else begin
            overrun_n = overrun_r;
          end
          if (level_n == HALF_LVL) begin
            state_n  = STREAM;
            primed_n = 1'b1;
          end else begin
            state_n = PRIME;
          end
        end
        STREAM: begin
          if (ready && (level_r == {ADDR_BITS{1'b0}})) begin
            underrun_n = 1'b1;
          end else begin
            underrun_n = underrun_r;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs; reset drops any in-flight write.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      wptr_r     <= {ADDR_BITS{1'b0}};
      level_r    <= {ADDR_BITS{1'b0}};
      primed_r   <= 1'b0;
      underrun_r <= 1'b0;
      overrun_r  <= 1'b0;
      wea_r      <= 1'b0;
      outa_r     <= {ADDR_BITS{1'b0}};
      outd_r     <= {DATA_BITS{1'b0}};
      fd_r       <= 1'b0;
    end else begin
      state_r    <= state_n;
      wptr_r     <= wptr_n;
      level_r    <= level_n;
      primed_r   <= primed_n;
      underrun_r <= underrun_n;
      overrun_r  <= overrun_n;
      wea_r      <= wea_n;
      outa_r     <= outa_n;
      outd_r     <= outd_n;
      fd_r       <= fd_n;
    end
  end

  assign in_ready   = in_ready_s;
  assign Outa       = outa_r;
  assign Outd       = outd_r;
  assign OutBufWea  = wea_r;
  assign primed     = primed_r;
  assign level      = level_r;
  assign frame_done = fd_r;
  assign underrun   = underrun_r;
  assign overrun    = overrun_r;

endmodule : out_buf_writer

// File: doc/out_buf_writer.md
# out_buf_writer

Write-side front end of the 768-entry output sample buffer. Accepts a stream of 16-bit samples on a valid/ready handshake and writes them to the buffer's write port (`Outa`/`Outd`/`OutBufWea`) at a wrapping address. Tracks occupancy against the read side's `ready` strobe, which advances the read counter once per output sample. Provides back-pressure on full, a `primed` flag once half a frame is buffered, and sticky under/overrun flags.

## Interface
- `DEPTH`, 768, buffer entries; write address wraps `DEPTH-1 -> 0`
- `ADDR_BITS`, 10, width of `Outa`
- `DATA_BITS`, 16, sample width
- `sys_clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; leaves IDLE
- `flush`  in  1  synchronous clear to IDLE; higher priority than all other inputs
- `in_valid`  in  1  sample offered
- `in_data`  in  DATA_BITS  sample (two's complement)
- `in_ready`  out  1  writer can accept
- `gain`  in  8  unsigned Q0.8 gain; used only with `OUTBUF_GAIN_EN`
- `ready`  in  1  read-side consume strobe, one per sample read
- `Outa`  out  ADDR_BITS  buffer write address
- `Outd`  out  DATA_BITS  buffer write data
- `OutBufWea`  out  1  buffer write enable
- `primed`  out  1  occupancy has reached DEPTH/2 since start
- `level`  out  ADDR_BITS  current occupancy, 0..DEPTH
- `frame_done`  out  1  one-cycle pulse when a write lands at address DEPTH-1
- `underrun`  out  1  sticky; `ready` seen with occupancy 0
- `overrun`  out  1  sticky; `ready` seen while not primed after start

## Operation
- States: IDLE, PRIME, STREAM.
- IDLE: `in_ready`=0 and `ready` is ignored. `start` moves to PRIME.
- PRIME: accepts samples and ignores `ready`, except that `ready` sets `overrun`. Moves to STREAM in the cycle the occupancy reaches DEPTH/2 (384). `primed` rises in that same cycle and stays high until IDLE.
- STREAM: accepts samples while the buffer is not full. Each `ready` decrements occupancy. `ready` at occupancy 0 sets `underrun` and leaves occupancy at 0.
- `in_ready` = (state != IDLE) && (level != DEPTH). It is combinational from registered state.
- Accept occurs when `in_valid && in_ready`. An accept increments occupancy and advances `wptr`.
- Simultaneous accept and `ready` in STREAM: occupancy unchanged.
- `wptr` increments 0..767 and wraps to 0. Its value is never 768.
- `flush`: `wptr`=0, `level`=0, flags cleared, state IDLE, no write that cycle. A pending accept in the same cycle is discarded.
- `start` outside IDLE is ignored. `start` together with `flush` results in IDLE.
- Reset (asynchronous, any time): all outputs 0, state IDLE, `wptr`=0. An in-flight write is dropped; `OutBufWea` deasserts immediately.

## Timing
- Write latency is 1 cycle: an accept at edge k drives `OutBufWea`=1, `Outa`=`wptr` before increment, and `Outd`=processed sample during cycle k..k+1. The RAM captures the write at edge k+1.
- `OutBufWea` is high for exactly one cycle per accepted sample. The block sustains back-to-back writes, 1 sample/cycle.
- `frame_done` is coincident with `OutBufWea` when `Outa`=767.
- `level` and `primed` update at the accept edge, one cycle ahead of the RAM write. The read side must read no earlier than 1 cycle after `primed`.

## Configuration
- `OUTBUF_GAIN_EN` defined: `Outd` = saturate16((`in_data` × `gain`) >>> 8). Product is 24 bits signed; arithmetic shift; clamp to [-32768, 32767]. `gain`=0xFF gives 255/256, not unity.
- Not defined: `Outd` = `in_data` unmodified, `gain` is unused, and no multiplier is synthesized. Latency is identical either way.

## Structure
- Shared package: `OUTBUF_DEPTH`=768, `OUTBUF_AW`=10, `SAMPLE_W`=16, and the state enum {IDLE, PRIME, STREAM}.
- One sub-module, `sat_gain`: combinational multiply, shift and clamp. Instantiated only under `OUTBUF_GAIN_EN`.
- Occupancy counter and write-address counter are local registers.

## Test plan
- Reset, `start`, then 384 back-to-back samples 0..383 -> writes land at addresses 0..383 with data = address; `primed` rises on the 384th accept; `level`=384.
- Continuous writes with no `ready` -> `in_ready` drops when `level`=768. The 769th sample is held, not written. Exactly 768 `OutBufWea` pulses and one `frame_done` at `Outa`=767.
- STREAM with `in_valid` and `ready` both asserted every cycle for 1000 cycles -> `level` is constant and `Outa` wraps 767->0 with no gap.
- `ready` at `level`=0 -> `underrun`=1 and `level` stays 0. `ready` during PRIME -> `overrun`=1. `flush` -> both flags clear, state IDLE.
- With `OUTBUF_GAIN_EN`: `gain`=0x80 and `in_data`=0x7FFF -> `Outd`=0x3FFF; `in_data`=0x8000 -> `Outd`=0xC000. `gain`=0xFF and `in_data`=-1 -> `Outd`=-1, from the arithmetic shift.
- `reset_n` asserted mid-burst, with `OutBufWea` high -> `OutBufWea`=0 asynchronously and all outputs 0. After release and `start`, the first write goes to address 0.
